// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-state encoding and default bus widths used by
// the requester and by the completer blocks hanging off the same bus.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns one valid/ready command at a time into an APB SETUP/ACCESS
// transfer and reports completion on a single-cycle response pulse.
// Optional feature macro APB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES
// cycles without pready and flag it with rsp_err. Without it ACCESS waits forever.
//
// state      | meaning
// -----------+----------------------------------------------------------
// APB_IDLE   | cmd_ready high, bus deselected, waiting for a command
// APB_SETUP  | psel high, penable low, exactly one cycle
// APB_ACCESS | psel and penable high, waiting for pready (or timeout)
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // A zero timeout would abort before the completer ever sees ACCESS.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_t        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last ACCESS cycle allowed to see pready==0 before the transfer is dropped.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        case (state_q)
            APB_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = APB_SETUP;
                end
            end

            APB_SETUP: begin
                penable_d = 1'b1;
                state_d   = APB_ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            APB_ACCESS: begin
                // pready has priority over a timeout landing in the same cycle.
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    cmd_ready_d = 1'b1;
                    state_d     = APB_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                    state_d     = APB_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = APB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= APB_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS wait-state counter for the timeout abort.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed commands with hand-computed
// responses pushed to a scoreboard queue, popped by an independent monitor.
// Covers the APB_TIMEOUT_EN build as well when that macro is defined.
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    int edge_cnt = 0;
    always @(posedge pclk) edge_cnt++;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          edge_n;   // posedge that registers rsp_valid, -1 = unchecked
        int          busy_n;   // cycles with psel high, -1 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Completer model: memory with a programmable number of wait states.
    int          waits = 0;
    bit          stuck = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    always @(negedge pclk) begin
        if (psel && penable) begin
            pready = !stuck && (acc_cnt >= waits);
            prdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
            if (pready && pwrite) mem[paddr] = pwdata;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'b0;
            prdata  = '0;
        end
    end

    // Monitor: bus-phase stability, idle gap, and response scoreboard.
    int psel_n = 0, pen_n = 0, gap_n = 0;
    bit prev_psel = 1'b0;
    bit gap_chk = 1'b0;

    always @(negedge pclk) begin
        if (!presetn) begin
            psel_n = 0; pen_n = 0; gap_n = 0; prev_psel = 1'b0;
        end else begin
            if (psel) begin
                if (!prev_psel && gap_chk) begin
                    check("idle_gap", gap_n, 1);
                    gap_chk = 1'b0;
                end
                psel_n++;
                gap_n = 0;
                if (penable) begin
                    pen_n++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", 1, 0);
                    end else begin
                        check("access_paddr", paddr, exp_q[0].addr);
                        check("access_pwrite", pwrite, exp_q[0].write);
                        if (exp_q[0].write) check("access_pwdata", pwdata, exp_q[0].wdata);
                    end
                end
            end else begin
                gap_n++;
            end
            prev_psel = psel;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    if (e.edge_n >= 0) check("rsp_latency", edge_cnt, e.edge_n);
                    if (e.busy_n >= 0) begin
                        check("psel_cycles", psel_n, e.busy_n);
                        check("penable_cycles", pen_n, e.busy_n - 1);
                    end
                end
                psel_n = 0;
                pen_n  = 0;
            end
        end
    end

    // Present a command and return on the negedge before its accept edge.
    task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input bit err, input int lat,
                        input int busy, input bit keep_valid);
        int tries = 0;
        @(negedge pclk);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && tries < 200) begin
            @(negedge pclk);
            tries++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back('{addr: a, write: wr, wdata: d, rdata: rd, err: err,
                              edge_n: (lat < 0) ? -1 : edge_cnt + 3 + lat, busy_n: busy});
            if (!keep_valid) begin
                @(posedge pclk);
                #1 cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge pclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge pclk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        presetn = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            check("idle_no_psel", psel, 0);
            check("idle_no_rsp", rsp_valid, 0);
        end

        // Zero-wait write.
        waits = 0;
        send(1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 2, 1'b0);
        wait_done(50);
        check("idle_paddr_hold", paddr, 32'h0);
        check("idle_pwdata_hold", pwdata, 32'hDEAD_BEEF);

        // Read with three wait states returns the written data.
        waits = 3;
        send(1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 5, 1'b0);
        wait_done(50);
        check("rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        // Back-to-back with cmd_valid held: write then read of the same word.
        waits = 0;
        send(1'b1, 32'h4, 32'h1234_5678, 32'h0, 1'b0, 0, 2, 1'b1);
        send(1'b0, 32'h4, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 0, 2, 1'b0);
        gap_chk = 1'b1;
        wait_done(50);
        check("gap_checked", gap_chk, 0);

        // Reset during ACCESS drops the transfer silently.
        waits = 100;
        send(1'b0, 32'h8, 32'h0, 32'h0, 1'b0, -1, -1, 1'b0);
        begin
            int n = 0;
            while (!(psel && penable) && n < 20) begin
                @(negedge pclk);
                n++;
            end
            check("reached_access", psel && penable, 1);
        end
        repeat (2) @(negedge pclk);
        presetn = 1'b0;
        void'(exp_q.pop_back());
        @(negedge pclk);
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        check("mid_rst_no_rsp", rsp_valid, 0);
        presetn = 1'b1;
        waits = 0;
        repeat (2) @(negedge pclk);

        // Completer that never answers.
`ifdef APB_TIMEOUT_EN
        stuck = 1'b1;
        send(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 15, 17, 1'b0);
        wait_done(60);
        stuck = 1'b0;
        waits = 15;
        send(1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 15, 17, 1'b0);
        wait_done(60);
        waits = 14;
        send(1'b1, 32'hC, 32'hA5A5_5A5A, 32'h0, 1'b0, 14, 16, 1'b0);
        wait_done(60);
`else
        stuck = 1'b1;
        send(1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, -1, -1, 1'b0);
        repeat (100) @(negedge pclk);
        check("still_waiting", psel && penable, 1);
        check("no_rsp_while_stuck", exp_q.size(), 1);
        stuck = 1'b0;
        wait_done(20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
